// File: rtl/muldiv_unit.sv
// muldiv_unit: multiply/divide unit that owns the HI/LO pair.
// Multiply family (MULT/MADD/MSUB/MUL) runs over MUL_STAGES cycles, DIV runs a
// restoring divider retiring DIV_BITS quotient bits per cycle. MTHI/MTLO write
// in a single cycle. cancel flushes any in-flight operation without commit.
//
// Handshake: an operation is taken on a rising edge when req_valid && req_ready
// && !cancel && req_op != 7. req_ready is simply !busy, so nothing is accepted
// while a multi-cycle operation is in flight and results commit in issue order.
module muldiv_unit #(
   parameter int DATA_W     = 32,
   parameter int MUL_STAGES = 2,
   parameter int DIV_BITS   = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic              req_signed,
   input  logic [DATA_W-1:0] req_x,
   input  logic [DATA_W-1:0] req_y,
   input  logic              cancel,
   output logic              busy,
   output logic              done,
   output logic              gpr_valid,
   output logic [DATA_W-1:0] gpr_data,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic [2:0]        dbg_state
);

   localparam int DIV_ITERS = DATA_W / DIV_BITS;
   localparam int CNT_MAX   = (MUL_STAGES > DIV_ITERS) ? MUL_STAGES : DIV_ITERS;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic [2:0] OP_MULT = 3'd0;
   localparam logic [2:0] OP_DIV  = 3'd1;
   localparam logic [2:0] OP_MADD = 3'd2;
   localparam logic [2:0] OP_MSUB = 3'd3;
   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;
   localparam logic [2:0] OP_MUL  = 3'd6;
   localparam logic [2:0] OP_RSVD = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_MUL      = 3'd1,
      S_DIV_PREP = 3'd2,
      S_DIV_ITER = 3'd3,
      S_DIV_FIX  = 3'd4,
      S_CMT      = 3'd5
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [2:0]            r_op;
   logic                  r_sgn;
   logic [DATA_W-1:0]     r_x;
   logic [DATA_W-1:0]     r_y;
   logic [2*DATA_W-1:0]   r_prod;
   logic [DATA_W-1:0]     r_quo;
   logic [DATA_W-1:0]     r_rem;
   logic [DATA_W-1:0]     r_dvs;
   logic                  r_neg_q;
   logic                  r_neg_r;
   logic                  r_dz;
   logic [DATA_W-1:0]     r_res_hi;
   logic [DATA_W-1:0]     r_res_lo;
   logic [DATA_W-1:0]     r_hi;
   logic [DATA_W-1:0]     r_lo;
   logic                  r_done;
   logic                  r_gpr_valid;
   logic [DATA_W-1:0]     r_gpr_data;

   logic                  w_accept;
   logic                  w_x_neg;
   logic                  w_y_neg;
   logic [DATA_W-1:0]     w_abs_x;
   logic [DATA_W-1:0]     w_abs_y;
   logic [2*DATA_W-1:0]   w_ext_x;
   logic [2*DATA_W-1:0]   w_ext_y;
   logic [2*DATA_W-1:0]   w_prod;
   logic [DATA_W-1:0]     w_quo_nxt;
   logic [DATA_W-1:0]     w_rem_nxt;
   logic [DATA_W:0]       w_trial;

   assign w_accept  = req_valid && (r_state == S_IDLE) && !cancel && (req_op != OP_RSVD);
   assign req_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign gpr_valid = r_gpr_valid;
   assign gpr_data  = r_gpr_data;
   assign hi        = r_hi;
   assign lo        = r_lo;
   assign dbg_state = r_state;

   // Operand magnitudes and sign-corrected 2*DATA_W-bit extensions; the low
   // 2*DATA_W bits of the extended product are exact for both signednesses.
   assign w_x_neg = r_sgn & r_x[DATA_W-1];
   assign w_y_neg = r_sgn & r_y[DATA_W-1];
   assign w_abs_x = w_x_neg ? -r_x : r_x;
   assign w_abs_y = w_y_neg ? -r_y : r_y;
   assign w_ext_x = r_sgn ? {{DATA_W{r_x[DATA_W-1]}}, r_x} : {{DATA_W{1'b0}}, r_x};
   assign w_ext_y = r_sgn ? {{DATA_W{r_y[DATA_W-1]}}, r_y} : {{DATA_W{1'b0}}, r_y};
   assign w_prod  = w_ext_x * w_ext_y;

   // One divider cycle: DIV_BITS restoring steps, dividend bits shift out of
   // the quotient register's top while quotient bits shift in at the bottom.
   always_comb begin
      w_quo_nxt = r_quo;
      w_rem_nxt = r_rem;
      w_trial   = '0;
      for (int b = 0; b < DIV_BITS; b++) begin
         w_trial   = {w_rem_nxt, w_quo_nxt[DATA_W-1]};
         w_quo_nxt = {w_quo_nxt[DATA_W-2:0], 1'b0};
         if (w_trial >= {1'b0, r_dvs}) begin
            w_trial      = w_trial - {1'b0, r_dvs};
            w_quo_nxt[0] = 1'b1;
         end
         w_rem_nxt = w_trial[DATA_W-1:0];
      end
   end

   // Control FSM plus datapath and architectural registers; cancel in any busy
   // state returns to IDLE and drops the partial result.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_hi        <= '0;
         r_lo        <= '0;
         r_done      <= 1'b0;
         r_gpr_valid <= 1'b0;
         r_gpr_data  <= '0;
      end else begin
         r_done      <= 1'b0;
         r_gpr_valid <= 1'b0;
         if (cancel && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     case (req_op)
                        OP_MTHI: r_hi <= req_x;
                        OP_MTLO: r_lo <= req_x;
                        OP_DIV: begin
                           r_op    <= req_op;
                           r_sgn   <= req_signed;
                           r_x     <= req_x;
                           r_y     <= req_y;
                           r_state <= S_DIV_PREP;
                        end
                        default: begin
                           r_op    <= req_op;
                           r_sgn   <= req_signed;
                           r_x     <= req_x;
                           r_y     <= req_y;
                           r_cnt   <= CNT_W'(MUL_STAGES);
                           r_state <= S_MUL;
                        end
                     endcase
                  end
               end
               S_MUL: begin
                  r_prod <= w_prod;
                  if (r_cnt == CNT_ONE) r_state <= S_CMT;
                  else                  r_cnt   <= r_cnt - CNT_ONE;
               end
               S_DIV_PREP: begin
                  r_quo   <= w_abs_x;
                  r_rem   <= '0;
                  r_dvs   <= w_abs_y;
                  r_neg_q <= w_x_neg ^ w_y_neg;
                  r_neg_r <= w_x_neg;
                  r_dz    <= (r_y == '0);
                  r_cnt   <= CNT_W'(DIV_ITERS);
                  r_state <= S_DIV_ITER;
               end
               S_DIV_ITER: begin
                  r_quo <= w_quo_nxt;
                  r_rem <= w_rem_nxt;
                  if (r_cnt == CNT_ONE) r_state <= S_DIV_FIX;
                  else                  r_cnt   <= r_cnt - CNT_ONE;
               end
               S_DIV_FIX: begin
                  // Divide by zero yields hi=x, lo=all-ones regardless of signedness.
                  if (r_dz) begin
                     r_res_hi <= r_x;
                     r_res_lo <= '1;
                  end else begin
                     r_res_lo <= r_neg_q ? -r_quo : r_quo;
                     r_res_hi <= r_neg_r ? -r_rem : r_rem;
                  end
                  r_state <= S_CMT;
               end
               S_CMT: begin
                  case (r_op)
                     OP_MULT: {r_hi, r_lo} <= r_prod;
                     OP_MADD: {r_hi, r_lo} <= {r_hi, r_lo} + r_prod;
                     OP_MSUB: {r_hi, r_lo} <= {r_hi, r_lo} - r_prod;
                     OP_MUL: begin
                        r_gpr_data  <= r_prod[DATA_W-1:0];
                        r_gpr_valid <= 1'b1;
                     end
                     OP_DIV: begin
                        r_hi <= r_res_hi;
                        r_lo <= r_res_lo;
                     end
                     default: ;
                  endcase
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit default instance and a
// 16-bit / 4-stage / 4-bit-per-cycle instance.
module tb_muldiv_unit;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn_a, rstn_b;

   // ---------------- instance a (32/2/1) ----------------
   logic        a_valid, a_ready, a_sgn, a_cancel, a_busy, a_done, a_gv;
   logic [2:0]  a_op, a_st;
   logic [31:0] a_x, a_y, a_gd, a_hi, a_lo;

   muldiv_unit #(.DATA_W(32), .MUL_STAGES(2), .DIV_BITS(1)) u_a (
      .clk(clk), .resetn(rstn_a), .req_valid(a_valid), .req_ready(a_ready),
      .req_op(a_op), .req_signed(a_sgn), .req_x(a_x), .req_y(a_y),
      .cancel(a_cancel), .busy(a_busy), .done(a_done), .gpr_valid(a_gv),
      .gpr_data(a_gd), .hi(a_hi), .lo(a_lo), .dbg_state(a_st)
   );

   // ---------------- instance b (16/4/4) ----------------
   logic        b_valid, b_ready, b_sgn, b_cancel, b_busy, b_done, b_gv;
   logic [2:0]  b_op, b_st;
   logic [15:0] b_x, b_y, b_gd, b_hi, b_lo;

   muldiv_unit #(.DATA_W(16), .MUL_STAGES(4), .DIV_BITS(4)) u_b (
      .clk(clk), .resetn(rstn_b), .req_valid(b_valid), .req_ready(b_ready),
      .req_op(b_op), .req_signed(b_sgn), .req_x(b_x), .req_y(b_y),
      .cancel(b_cancel), .busy(b_busy), .done(b_done), .gpr_valid(b_gv),
      .gpr_data(b_gd), .hi(b_hi), .lo(b_lo), .dbg_state(b_st)
   );

   // ---------------- scoreboard ----------------
   int n_chk = 0;
   int n_err = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Issue a multi-cycle op on a, wait for done, check against exp_q head.
   task automatic op_a(input string tag, input logic [2:0] op, input logic s,
                       input logic [31:0] x, input logic [31:0] y,
                       input int exp_lat, input logic [31:0] exp_gd);
      int lat;
      int bcyc;
      logic [63:0] exp;
      @(negedge clk);
      a_valid = 1'b1; a_op = op; a_sgn = s; a_x = x; a_y = y;
      @(posedge clk); #1;
      a_valid = 1'b0;
      bcyc = a_busy ? 1 : 0;
      lat  = 0;
      while (!a_done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (a_busy) bcyc++;
      end
      exp = exp_q.pop_front();
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy_cycles"}, 64'(bcyc), 64'(exp_lat));
      check({tag, " ready_at_done"}, {63'd0, a_ready}, 64'd1);
      check({tag, " hilo"}, {a_hi, a_lo}, exp);
      check({tag, " gpr_valid"}, {63'd0, a_gv}, {63'd0, (op == 3'd6)});
      if (op == 3'd6) check({tag, " gpr_data"}, {32'd0, a_gd}, {32'd0, exp_gd});
      @(posedge clk); #1;
      check({tag, " done_one_cycle"}, {63'd0, a_done}, 64'd0);
   endtask

   // Single-cycle MTHI/MTLO on a.
   task automatic mt_a(input logic [2:0] op, input logic [31:0] x);
      @(negedge clk);
      a_valid = 1'b1; a_op = op; a_sgn = 1'b0; a_x = x; a_y = '0;
      @(posedge clk); #1;
      a_valid = 1'b0;
   endtask

   task automatic op_b(input string tag, input logic [2:0] op, input logic s,
                       input logic [15:0] x, input logic [15:0] y, input int exp_lat);
      int lat;
      logic [63:0] exp;
      @(negedge clk);
      b_valid = 1'b1; b_op = op; b_sgn = s; b_x = x; b_y = y;
      @(posedge clk); #1;
      b_valid = 1'b0;
      lat = 0;
      while (!b_done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      exp = exp_q.pop_front();
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " hilo"}, {32'd0, b_hi, b_lo}, exp);
      @(posedge clk); #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rstn_a = 1'b0; rstn_b = 1'b0;
      a_valid = 1'b0; a_op = '0; a_sgn = 1'b0; a_x = '0; a_y = '0; a_cancel = 1'b0;
      b_valid = 1'b0; b_op = '0; b_sgn = 1'b0; b_x = '0; b_y = '0; b_cancel = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst hi", {32'd0, a_hi}, 64'd0);
      check("rst lo", {32'd0, a_lo}, 64'd0);
      check("rst busy", {63'd0, a_busy}, 64'd0);
      check("rst done", {63'd0, a_done}, 64'd0);
      check("rst gpr_valid", {63'd0, a_gv}, 64'd0);
      check("rst gpr_data", {32'd0, a_gd}, 64'd0);
      check("rst ready", {63'd0, a_ready}, 64'd1);
      rstn_a = 1'b1; rstn_b = 1'b1;

      // MULT / DIV
      exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
      op_a("mult_s", 3'd0, 1'b1, 32'hFFFFFFFE, 32'd3, 3, 32'd0);
      exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
      op_a("div_s_m7_2", 3'd1, 1'b1, 32'hFFFFFFF9, 32'd2, 35, 32'd0);
      exp_q.push_back(64'h00000007_FFFFFFFF);
      op_a("div_u_7_0", 3'd1, 1'b0, 32'd7, 32'd0, 35, 32'd0);
      exp_q.push_back(64'hFFFFFFF9_FFFFFFFF);
      op_a("div_s_m7_0", 3'd1, 1'b1, 32'hFFFFFFF9, 32'd0, 35, 32'd0);
      exp_q.push_back(64'h00000000_80000000);
      op_a("div_s_ovf", 3'd1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 35, 32'd0);
      exp_q.push_back(64'h00000001_FFFFFFFD);
      op_a("div_s_7_m2", 3'd1, 1'b1, 32'd7, 32'hFFFFFFFE, 35, 32'd0);
      exp_q.push_back(64'h00000005_19999999);
      op_a("div_u_big", 3'd1, 1'b0, 32'hFFFFFFFF, 32'd10, 35, 32'd0);

      // MTHI/MTLO and accumulate
      mt_a(3'd4, 32'h12345678);
      check("mthi hi", {32'd0, a_hi}, 64'h12345678);
      check("mthi busy", {63'd0, a_busy}, 64'd0);
      mt_a(3'd5, 32'h00000001);
      check("mtlo lo", {32'd0, a_lo}, 64'h1);
      check("mtlo done", {63'd0, a_done}, 64'd0);
      exp_q.push_back(64'h12345679_FFFFFFFF);
      op_a("maddu", 3'd2, 1'b0, 32'hFFFFFFFF, 32'd2, 3, 32'd0);
      mt_a(3'd4, 32'd0);
      mt_a(3'd5, 32'd0);
      exp_q.push_back(64'hFFFFFFFF_FFFFFFFF);
      op_a("msub_s", 3'd3, 1'b1, 32'd1, 32'd1, 3, 32'd0);
      exp_q.push_back(64'hFFFFFFFF_FFFFFFF9);
      op_a("madd_s", 3'd2, 1'b1, 32'hFFFFFFFE, 32'd3, 3, 32'd0);

      // MUL to GPR
      mt_a(3'd4, 32'hA5A5A5A5);
      mt_a(3'd5, 32'hA5A5A5A5);
      exp_q.push_back(64'hA5A5A5A5_A5A5A5A5);
      op_a("mul_u", 3'd6, 1'b0, 32'h00010000, 32'h00010000, 3, 32'd0);
      exp_q.push_back(64'hA5A5A5A5_A5A5A5A5);
      op_a("mul_s", 3'd6, 1'b1, 32'd7, 32'hFFFFFFFD, 3, 32'hFFFFFFEB);

      // Cancel a DIV in its 10th cycle, then a MULT right after
      @(negedge clk);
      a_valid = 1'b1; a_op = 3'd1; a_sgn = 1'b0; a_x = 32'd100; a_y = 32'd7;
      @(posedge clk); #1;
      a_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      a_cancel = 1'b1;
      @(posedge clk); #1;
      a_cancel = 1'b0;
      check("cancel busy", {63'd0, a_busy}, 64'd0);
      check("cancel done", {63'd0, a_done}, 64'd0);
      check("cancel hilo", {a_hi, a_lo}, 64'hA5A5A5A5_A5A5A5A5);
      exp_q.push_back(64'h00000000_0000001E);
      op_a("mult_after_cancel", 3'd0, 1'b0, 32'd5, 32'd6, 3, 32'd0);

      // cancel in IDLE and reserved op are not accepted
      @(negedge clk);
      a_valid = 1'b1; a_op = 3'd4; a_x = 32'hDEADBEEF; a_cancel = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b0; a_cancel = 1'b0;
      check("idle_cancel hi", {32'd0, a_hi}, 64'h0);
      @(negedge clk);
      a_valid = 1'b1; a_op = 3'd7; a_x = 32'd3; a_y = 32'd3;
      @(posedge clk); #1;
      a_valid = 1'b0;
      check("op7 busy", {63'd0, a_busy}, 64'd0);
      check("op7 hilo", {a_hi, a_lo}, 64'h00000000_0000001E);

      // Reset in the 5th cycle of a DIV
      mt_a(3'd4, 32'h00000042);
      @(negedge clk);
      a_valid = 1'b1; a_op = 3'd1; a_sgn = 1'b0; a_x = 32'd50; a_y = 32'd3;
      @(posedge clk); #1;
      a_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rstn_a = 1'b0;
      @(posedge clk); #1;
      rstn_a = 1'b1;
      check("midrst hilo", {a_hi, a_lo}, 64'd0);
      check("midrst busy", {63'd0, a_busy}, 64'd0);
      check("midrst state", {61'd0, a_st}, 64'd0);

      // Instance b: 16-bit, 4 multiplier stages, 4 quotient bits per cycle
      exp_q.push_back(64'h00000000_FFFFFFFA);
      op_b("b_mult_s", 3'd0, 1'b1, 16'hFFFE, 16'd3, 5);
      exp_q.push_back(64'h00000000_FFFFFFFD);
      op_b("b_div_s", 3'd1, 1'b1, 16'hFFF9, 16'd2, 7);
      exp_q.push_back(64'h00000000_00008000);
      op_b("b_div_ovf", 3'd1, 1'b1, 16'h8000, 16'hFFFF, 7);
      exp_q.push_back(64'h00000000_0006008E);
      op_b("b_div_u", 3'd1, 1'b0, 16'd1000, 16'd7, 7);
      @(negedge clk);
      b_valid = 1'b1; b_op = 3'd1; b_sgn = 1'b0; b_x = 16'd99; b_y = 16'd4;
      @(posedge clk); #1;
      b_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      check("b_midrst busy_before", {63'd0, b_busy}, 64'd1);
      rstn_b = 1'b0;
      @(posedge clk); #1;
      rstn_b = 1'b1;
      check("b_midrst hilo", {32'd0, b_hi, b_lo}, 64'd0);
      check("b_midrst busy", {63'd0, b_busy}, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
